// File: rtl/simon_rng_if.sv
// Valid/ready word channel between the RNG source (master) and its consumer (slave).
interface simon_rng_if;
   logic        rng_valid;
   logic        rng_ready;
   logic [31:0] rng_out;

   modport master (output rng_valid, output rng_out, input rng_ready);
   modport slave  (input rng_valid, input rng_out, output rng_ready);
endinterface

// File: rtl/simon_rng_source.sv
// Free-running 32-bit Galois LFSR offering spaced random words over valid/ready.
// Optional button-timing entropy mix enabled by defining SIMON_RNG_ENTROPY_EN.
module simon_rng_source #(
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
   parameter logic [31:0] TAPS         = 32'h8020_0003,
   parameter int          WARMUP       = 64,
   parameter int          SPACING      = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        seed_load,
   input  logic [31:0] seed_in,
   input  logic [3:0]  entropy_in,
   simon_rng_if.master rng
);

   localparam int CNT_MAX = (WARMUP > SPACING) ? WARMUP : SPACING;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {ST_WARMUP, ST_OFFER, ST_SPACE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [31:0]   out_q, out_d;
   logic          valid_q, valid_d;
   logic [31:0]   lfsr_adv, lfsr_mix, lfsr_cand;

`ifdef SIMON_RNG_ENTROPY_EN
   logic [3:0] ent_s1_q, ent_s2_q, ent_s3_q;
   logic [7:0] ts_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_s1_q <= '0;
         ent_s2_q <= '0;
         ent_s3_q <= '0;
         ts_q     <= '0;
      end else begin
         ent_s1_q <= entropy_in;
         ent_s2_q <= ent_s1_q;
         ent_s3_q <= ent_s2_q;
         ts_q     <= ts_q + 8'd1;
      end
   end
`else
   logic unused_entropy;
   assign unused_entropy = ^entropy_in;
`endif

   // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      lfsr_adv = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      lfsr_mix = lfsr_adv;
`ifdef SIMON_RNG_ENTROPY_EN
      if (|(ent_s2_q & ~ent_s3_q) && !seed_load)
         lfsr_mix[7:0] = lfsr_adv[7:0] ^ ts_q;
`endif
      if (seed_load)
         lfsr_cand = (seed_in == 32'h0) ? SEED_DEFAULT : seed_in;
      else
         lfsr_cand = lfsr_mix;
      // An all-zero Galois state is a fixed point; never let the register reach it.
      lfsr_d = (lfsr_cand == 32'h0) ? SEED_DEFAULT : lfsr_cand;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      out_d   = out_q;
      case (state_q)
         ST_WARMUP, ST_SPACE: begin
            if (cnt_q == CW'(1)) begin
               out_d   = lfsr_d;
               valid_d = 1'b1;
               state_d = ST_OFFER;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_OFFER: begin
            if (valid_q && rng.rng_ready) begin
               valid_d = 1'b0;
               cnt_d   = CW'(SPACING);
               state_d = ST_SPACE;
            end
         end
         default: state_d = ST_WARMUP;
      endcase
      // A reseed restarts spacing from the new seed so sequences are reproducible.
      if (seed_load) begin
         valid_d = 1'b0;
         cnt_d   = CW'(SPACING);
         state_d = ST_SPACE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_WARMUP;
         cnt_q   <= CW'(WARMUP);
         lfsr_q  <= SEED_DEFAULT;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign rng.rng_valid = valid_q;
   assign rng.rng_out   = out_q;

endmodule

// File: tb/tb_simon_rng_source.sv
// Scoreboard bench for simon_rng_source with WARMUP=4, SPACING=2.
module tb_simon_rng_source;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        seed_load = 1'b0;
   logic [31:0] seed_in = '0;
   logic [3:0]  entropy_in = '0;

   simon_rng_if bus ();

   simon_rng_source #(.WARMUP(4), .SPACING(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .entropy_in (entropy_in),
      .rng        (bus.master)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          lfsr_zero = 0;
   logic [31:0] exp_q[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(string name);
      int n = 0;
      while (!bus.rng_valid && n < 50) begin
         step();
         n++;
      end
      check({name, "_valid"}, 32'(bus.rng_valid), 32'd1);
   endtask

   task automatic count_to_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.rng_valid && n < 50);
   endtask

   // Monitor: every accepted word is popped against the expected queue.
   always @(negedge clk) begin
      if (reset_n && dut.lfsr_q == 32'h0) lfsr_zero++;
      if (reset_n && bus.rng_valid && bus.rng_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got word %h expected no transfer", bus.rng_out);
         end else begin
            check("word", bus.rng_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      int low;
`ifdef SIMON_RNG_ENTROPY_EN
      logic [31:0] exp_ent = 32'h4010_0003;
`else
      logic [31:0] exp_ent = 32'hC030_0002;
`endif
      bus.rng_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.rng_valid), 32'd0);
      check("rst_out", bus.rng_out, 32'h0);

      // Case 1: warm-up latency and hold without ready
      reset_n = 1'b1;
      count_to_valid(n);
      check("warmup_cycles", 32'(n), 32'd4);
      exp_q.push_back(32'h8AEE_1245);
      for (int i = 0; i < 20; i++) begin
         check("hold_out", bus.rng_out, 32'h8AEE_1245);
         step();
      end
      bus.rng_ready = 1'b1;
      step();
      bus.rng_ready = 1'b0;

      // Case 2: seed 1, back-to-back consumption, 2-cycle gap
      seed_load = 1'b1;
      seed_in   = 32'h1;
      step();
      seed_load = 1'b0;
      exp_q.push_back(32'hC030_0002);
      exp_q.push_back(32'hD836_0002);
      exp_q.push_back(32'hDB36_C002);
      bus.rng_ready = 1'b1;
      wait_valid("c2_w1");
      step();
      low = 0;
      while (!bus.rng_valid && low < 20) begin
         low++;
         step();
      end
      check("c2_gap", 32'(low), 32'd2);
      step();
      wait_valid("c2_w3");
      step();
      bus.rng_ready = 1'b0;

      // Case 3: zero seed falls back to default; long run never hits zero
      seed_load = 1'b1;
      seed_in   = 32'h0;
      step();
      seed_load = 1'b0;
      exp_q.push_back(32'h2B38_491A);
      repeat (10000) step();
      check("c3_hold_out", bus.rng_out, 32'h2B38_491A);

      // Case 4: reseed in the same cycle as a handshake
      bus.rng_ready = 1'b1;
      seed_load     = 1'b1;
      seed_in       = 32'h1;
      step();
      bus.rng_ready = 1'b0;
      seed_load     = 1'b0;
      exp_q.push_back(32'hC030_0002);
      wait_valid("c4_w");
      bus.rng_ready = 1'b1;
      step();
      bus.rng_ready = 1'b0;

      // Case 5: asynchronous reset mid-SPACE
      #3;
      reset_n = 1'b0;
      #1;
      check("c5_valid", 32'(bus.rng_valid), 32'd0);
      check("c5_out", bus.rng_out, 32'h0);
      step();
      reset_n = 1'b1;
      exp_q.push_back(32'h8AEE_1245);
      count_to_valid(n);
      check("c5_warmup_cycles", 32'(n), 32'd4);
      bus.rng_ready = 1'b1;
      step();
      bus.rng_ready = 1'b0;

      // Case 6: entropy edge while timestamp is 5
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (3) step();
      entropy_in = 4'b0001;
      step();
      seed_load = 1'b1;
      seed_in   = 32'h1;
      step();
      seed_load = 1'b0;
      repeat (2) step();
      check("c6_valid", 32'(bus.rng_valid), 32'd1);
      exp_q.push_back(exp_ent);
      bus.rng_ready = 1'b1;
      step();
      bus.rng_ready = 1'b0;
      entropy_in = 4'b0000;
      repeat (3) step();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("lfsr_never_zero", 32'(lfsr_zero), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
